// File: rtl/xc_rf_wb_pkg.sv
// Shared types and constants for the register-file writeback controller.
package xc_rf_wb_pkg;

    localparam int XC_RF_WB_NSLOTS = 3;
    localparam int XC_RF_WB_AW     = 5;
    localparam int XC_RF_WB_DW     = 32;

    // One in-flight writeback entry; pending marks data that has not returned yet.
    typedef struct packed {
        logic                   valid;
        logic                   wen;
        logic [XC_RF_WB_AW-1:0] addr;
        logic [XC_RF_WB_DW-1:0] data;
        logic                   pending;
    } slot_t;

endpackage

// File: rtl/xc_rf_wb_hazard.sv
// Per-source stall detection: the youngest valid writing slot that matches the
// source address decides, so a stall is raised only if that slot is still pending.
module xc_rf_wb_hazard
    import xc_rf_wb_pkg::*;
(
    input  logic [XC_RF_WB_NSLOTS-1:0]             valid_i,
    input  logic [XC_RF_WB_NSLOTS-1:0]             wen_i,
    input  logic [XC_RF_WB_NSLOTS-1:0]             pending_i,
    input  logic [XC_RF_WB_NSLOTS*XC_RF_WB_AW-1:0] addr_i,
    input  logic [XC_RF_WB_AW-1:0]                 rs_addr_i,
    output logic                                   stall_o
);

    // Walk oldest to youngest so the youngest match overrides (slot 0 is youngest).
    always_comb begin
        stall_o = 1'b0;
        for (int i = XC_RF_WB_NSLOTS - 1; i >= 0; i--) begin
            if (valid_i[i] && wen_i[i] &&
                (addr_i[i*XC_RF_WB_AW +: XC_RF_WB_AW] == rs_addr_i)) begin
                stall_o = pending_i[i];
            end
        end
        if (rs_addr_i == '0) begin
            stall_o = 1'b0;
        end
    end

endmodule

// File: rtl/xc_rf_wb_ctrl.sv
// Three-slot writeback pipeline feeding two bypass ports and the register file
// write port. Late-result support is built only when XC_RF_WB_LATE_EN is defined.
module xc_rf_wb_ctrl
    import xc_rf_wb_pkg::*;
(
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   ex_valid_i,
    output logic                   ex_ready_o,
    input  logic                   ex_wen_i,
    input  logic [XC_RF_WB_AW-1:0] ex_addr_i,
    input  logic [XC_RF_WB_DW-1:0] ex_wdata_i,
    input  logic                   ex_late_i,
    input  logic                   late_valid_i,
    input  logic [XC_RF_WB_DW-1:0] late_wdata_i,
    output logic                   late_busy_o,
    output logic                   fwd_0_wen_o,
    output logic [XC_RF_WB_AW-1:0] fwd_0_addr_o,
    output logic [XC_RF_WB_DW-1:0] fwd_0_wdata_o,
    output logic                   fwd_1_wen_o,
    output logic [XC_RF_WB_AW-1:0] fwd_1_addr_o,
    output logic [XC_RF_WB_DW-1:0] fwd_1_wdata_o,
    output logic                   rd_wen_o,
    output logic [XC_RF_WB_AW-1:0] rd_addr_o,
    output logic [XC_RF_WB_DW-1:0] rd_wdata_o,
    input  logic [XC_RF_WB_AW-1:0] rs1_addr_i,
    input  logic [XC_RF_WB_AW-1:0] rs2_addr_i,
    output logic                   rs1_stall_o,
    output logic                   rs2_stall_o
);

    // Index 0 is S0 (youngest), index 2 is S2 (oldest, commit side).
    slot_t [XC_RF_WB_NSLOTS-1:0] slot_q, slot_d, slot_c;

    logic late_busy;
    logic advance;
    logic accept;
    logic new_wen;

`ifdef XC_RF_WB_LATE_EN
    // Any valid pending slot blocks new entries; only a pending S2 freezes the shift.
    always_comb begin
        late_busy = 1'b0;
        for (int i = 0; i < XC_RF_WB_NSLOTS; i++) begin
            late_busy = late_busy | (slot_q[i].valid & slot_q[i].pending);
        end
    end
    assign advance = ~(slot_q[XC_RF_WB_NSLOTS-1].valid & slot_q[XC_RF_WB_NSLOTS-1].pending);
`else
    logic unused_late;
    assign unused_late = ^{ex_late_i, late_valid_i, late_wdata_i};
    assign late_busy   = 1'b0;
    assign advance     = 1'b1;
`endif

    assign ex_ready_o  = advance & ~late_busy;
    assign late_busy_o = late_busy;
    assign accept      = ex_valid_i & ex_ready_o;
    assign new_wen     = ex_wen_i & (|ex_addr_i);

    // Late data lands in whichever slot is pending, before any shift is applied.
    always_comb begin
        slot_c = slot_q;
`ifdef XC_RF_WB_LATE_EN
        if (late_valid_i && late_busy) begin
            for (int i = 0; i < XC_RF_WB_NSLOTS; i++) begin
                if (slot_q[i].valid && slot_q[i].pending) begin
                    slot_c[i].data    = late_wdata_i;
                    slot_c[i].pending = 1'b0;
                end
            end
        end
`endif
    end

    // Shift the pipeline on advance and load S0 from the execute handshake.
    always_comb begin
        slot_d = slot_c;
        if (advance) begin
            for (int i = XC_RF_WB_NSLOTS - 1; i > 0; i--) begin
                slot_d[i] = slot_c[i-1];
            end
            slot_d[0].valid = accept;
            slot_d[0].wen   = new_wen;
            slot_d[0].addr  = ex_addr_i;
            slot_d[0].data  = ex_wdata_i;
`ifdef XC_RF_WB_LATE_EN
            slot_d[0].pending = accept & ex_late_i & new_wen;
`else
            slot_d[0].pending = 1'b0;
`endif
        end
    end

    // Slot state register with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Bypass and commit ports come straight from the slots.
    always_comb begin
        fwd_0_wen_o   = slot_q[0].valid & slot_q[0].wen & ~slot_q[0].pending;
        fwd_0_addr_o  = slot_q[0].addr;
        fwd_0_wdata_o = slot_q[0].data;
        fwd_1_wen_o   = slot_q[1].valid & slot_q[1].wen & ~slot_q[1].pending;
        fwd_1_addr_o  = slot_q[1].addr;
        fwd_1_wdata_o = slot_q[1].data;
        rd_wen_o      = slot_q[2].valid & slot_q[2].wen & ~slot_q[2].pending;
        rd_addr_o     = slot_q[2].addr;
        rd_wdata_o    = slot_q[2].data;
    end

    logic [XC_RF_WB_NSLOTS-1:0]             haz_valid;
    logic [XC_RF_WB_NSLOTS-1:0]             haz_wen;
    logic [XC_RF_WB_NSLOTS-1:0]             haz_pending;
    logic [XC_RF_WB_NSLOTS*XC_RF_WB_AW-1:0] haz_addr;

    // Flatten slot fields for the hazard checkers.
    always_comb begin
        haz_valid   = '0;
        haz_wen     = '0;
        haz_pending = '0;
        haz_addr    = '0;
        for (int i = 0; i < XC_RF_WB_NSLOTS; i++) begin
            haz_valid[i]                           = slot_q[i].valid;
            haz_wen[i]                             = slot_q[i].wen;
            haz_pending[i]                         = slot_q[i].pending;
            haz_addr[i*XC_RF_WB_AW +: XC_RF_WB_AW] = slot_q[i].addr;
        end
    end

    xc_rf_wb_hazard u_hazard_rs1 (
        .valid_i   (haz_valid),
        .wen_i     (haz_wen),
        .pending_i (haz_pending),
        .addr_i    (haz_addr),
        .rs_addr_i (rs1_addr_i),
        .stall_o   (rs1_stall_o)
    );

    xc_rf_wb_hazard u_hazard_rs2 (
        .valid_i   (haz_valid),
        .wen_i     (haz_wen),
        .pending_i (haz_pending),
        .addr_i    (haz_addr),
        .rs_addr_i (rs2_addr_i),
        .stall_o   (rs2_stall_o)
    );

endmodule

// File: tb/tb_xc_rf_wb_ctrl.sv
// Bench for xc_rf_wb_ctrl: directed scenarios plus random traffic, all checked
// against a queue-based reference model. Honours XC_RF_WB_LATE_EN like the design.
module tb_xc_rf_wb_ctrl;

`ifdef XC_RF_WB_LATE_EN
    localparam bit LateEn = 1'b1;
`else
    localparam bit LateEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_wen, ex_late, late_valid;
    logic [4:0]  ex_addr, rs1_addr, rs2_addr;
    logic [31:0] ex_wdata, late_wdata;
    logic        ex_ready, late_busy;
    logic        fwd_0_wen, fwd_1_wen, rd_wen, rs1_stall, rs2_stall;
    logic [4:0]  fwd_0_addr, fwd_1_addr, rd_addr;
    logic [31:0] fwd_0_wdata, fwd_1_wdata, rd_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xc_rf_wb_ctrl dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .ex_valid_i    (ex_valid),
        .ex_ready_o    (ex_ready),
        .ex_wen_i      (ex_wen),
        .ex_addr_i     (ex_addr),
        .ex_wdata_i    (ex_wdata),
        .ex_late_i     (ex_late),
        .late_valid_i  (late_valid),
        .late_wdata_i  (late_wdata),
        .late_busy_o   (late_busy),
        .fwd_0_wen_o   (fwd_0_wen),
        .fwd_0_addr_o  (fwd_0_addr),
        .fwd_0_wdata_o (fwd_0_wdata),
        .fwd_1_wen_o   (fwd_1_wen),
        .fwd_1_addr_o  (fwd_1_addr),
        .fwd_1_wdata_o (fwd_1_wdata),
        .rd_wen_o      (rd_wen),
        .rd_addr_o     (rd_addr),
        .rd_wdata_o    (rd_wdata),
        .rs1_addr_i    (rs1_addr),
        .rs2_addr_i    (rs2_addr),
        .rs1_stall_o   (rs1_stall),
        .rs2_stall_o   (rs2_stall)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an ordered list of in-flight results, oldest first.
    typedef struct packed {
        bit        v;
        bit        w;
        bit [4:0]  a;
        bit [31:0] d;
        bit        p;
    } ent_t;

    ent_t pipe[$];

    task automatic model_reset();
        ent_t e;
        e = '0;
        pipe.delete();
        repeat (3) pipe.push_back(e);
    endtask

    function automatic bit m_busy();
        bit r = 1'b0;
        foreach (pipe[i]) if (pipe[i].v && pipe[i].p) r = 1'b1;
        return r;
    endfunction

    function automatic bit m_ready();
        return !(pipe[0].v && pipe[0].p) && !m_busy();
    endfunction

    function automatic bit m_wen(int idx);
        return pipe[idx].v && pipe[idx].w && !pipe[idx].p;
    endfunction

    // Youngest writer of rs decides whether the source must wait.
    function automatic bit m_stall(bit [4:0] rs);
        bit r = 1'b0;
        bit found = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            if (!found && rs != 0 && pipe[i].v && pipe[i].w && pipe[i].a == rs) begin
                found = 1'b1;
                r = pipe[i].p;
            end
        end
        return r;
    endfunction

    task automatic model_step();
        ent_t e;
        bit   busy, adv, rdy;
        if (rst) begin
            model_reset();
        end else begin
            busy = m_busy();
            adv  = !(pipe[0].v && pipe[0].p);
            rdy  = adv && !busy;
            if (LateEn && late_valid && busy) begin
                foreach (pipe[i]) begin
                    if (pipe[i].v && pipe[i].p) begin
                        pipe[i].d = late_wdata;
                        pipe[i].p = 1'b0;
                    end
                end
            end
            if (adv) begin
                void'(pipe.pop_front());
                e = '0;
                if (ex_valid && rdy) begin
                    e.v = 1'b1;
                    e.w = ex_wen && (ex_addr != 0);
                    e.a = ex_addr;
                    e.d = ex_wdata;
                    e.p = LateEn && ex_late && e.w;
                end
                pipe.push_back(e);
            end
        end
    endtask

    task automatic compare_all();
        check_eq("ex_ready", ex_ready, m_ready());
        check_eq("late_busy", late_busy, m_busy());
        check_eq("rs1_stall", rs1_stall, m_stall(rs1_addr));
        check_eq("rs2_stall", rs2_stall, m_stall(rs2_addr));
        check_eq("fwd_0_wen", fwd_0_wen, m_wen(2));
        if (m_wen(2)) begin
            check_eq("fwd_0_addr", fwd_0_addr, pipe[2].a);
            check_eq("fwd_0_wdata", fwd_0_wdata, pipe[2].d);
        end
        check_eq("fwd_1_wen", fwd_1_wen, m_wen(1));
        if (m_wen(1)) begin
            check_eq("fwd_1_addr", fwd_1_addr, pipe[1].a);
            check_eq("fwd_1_wdata", fwd_1_wdata, pipe[1].d);
        end
        check_eq("rd_wen", rd_wen, m_wen(0));
        if (m_wen(0)) begin
            check_eq("rd_addr", rd_addr, pipe[0].a);
            check_eq("rd_wdata", rd_wdata, pipe[0].d);
        end
    endtask

    // One clock: compare mid-cycle, advance the model, return just after the edge.
    task automatic cycle();
        @(negedge clk);
        compare_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit w, input bit [4:0] a, input bit [31:0] d,
                         input bit late, input bit lv, input bit [31:0] ld);
        ex_valid   = v;
        ex_wen     = w;
        ex_addr    = a;
        ex_wdata   = d;
        ex_late    = late;
        late_valid = lv;
        late_wdata = ld;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic pipeline_pair(input bit late, input bit lv);
        drive(1'b1, 1'b1, 5'd5, 32'h11, late, lv, 32'hDEAD);
        cycle();
        check_eq("pipe_fwd0_wen_x5", fwd_0_wen, 1'b1);
        check_eq("pipe_fwd0_addr_x5", fwd_0_addr, 5'd5);
        check_eq("pipe_fwd0_data_x5", fwd_0_wdata, 32'h11);
        drive(1'b1, 1'b1, 5'd6, 32'h22, late, lv, 32'hBEEF);
        cycle();
        check_eq("pipe_fwd0_addr_x6", fwd_0_addr, 5'd6);
        check_eq("pipe_fwd1_addr_x5", fwd_1_addr, 5'd5);
        drive(1'b0, 1'b0, 5'd0, 32'h0, late, lv, 32'h1234);
        cycle();
        check_eq("pipe_rd_wen_x5", rd_wen, 1'b1);
        check_eq("pipe_rd_addr_x5", rd_addr, 5'd5);
        check_eq("pipe_rd_data_x5", rd_wdata, 32'h11);
        cycle();
        check_eq("pipe_rd_wen_x6", rd_wen, 1'b1);
        check_eq("pipe_rd_addr_x6", rd_addr, 5'd6);
        check_eq("pipe_rd_data_x6", rd_wdata, 32'h22);
        idle();
        repeat (2) cycle();
    endtask

    initial begin
        rst = 1'b1;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_eq("rst_fwd0_wen", fwd_0_wen, 1'b0);
        check_eq("rst_fwd1_wen", fwd_1_wen, 1'b0);
        check_eq("rst_rd_wen", rd_wen, 1'b0);
        check_eq("rst_late_busy", late_busy, 1'b0);
        check_eq("rst_rs1_stall", rs1_stall, 1'b0);
        check_eq("rst_rs2_stall", rs2_stall, 1'b0);
        check_eq("rst_ex_ready", ex_ready, 1'b1);
        rst = 1'b0;

        // Back-to-back writes through all three stages.
        pipeline_pair(1'b0, 1'b0);

`ifdef XC_RF_WB_LATE_EN
        // Late result freezes the pipe at S2 until the data returns.
        rs1_addr = 5'd7;
        drive(1'b1, 1'b1, 5'd7, 32'h0, 1'b1, 1'b0, 32'h0);
        cycle();
        check_eq("late_ready_low", ex_ready, 1'b0);
        check_eq("late_busy_high", late_busy, 1'b1);
        check_eq("late_rs1_stall_s0", rs1_stall, 1'b1);
        drive(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 32'h0);
        repeat (2) cycle();
        check_eq("late_frozen_rd_wen", rd_wen, 1'b0);
        check_eq("late_rs1_stall_s2", rs1_stall, 1'b1);
        rs2_addr = 5'd0;
        check_eq("late_rs2_zero", rs2_stall, 1'b0);
        repeat (2) cycle();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'hABCD);
        cycle();
        check_eq("late_rd_wen", rd_wen, 1'b1);
        check_eq("late_rd_addr", rd_addr, 5'd7);
        check_eq("late_rd_data", rd_wdata, 32'hABCD);
        check_eq("late_ready_back", ex_ready, 1'b1);
        idle();
        repeat (3) cycle();

        // Older committed x3 followed by a younger pending x3: the pending one wins.
        rs1_addr = 5'd3;
        drive(1'b1, 1'b1, 5'd3, 32'h5, 1'b0, 1'b0, 32'h0);
        cycle();
        check_eq("haz_nonpend_x3", rs1_stall, 1'b0);
        drive(1'b1, 1'b1, 5'd3, 32'h0, 1'b1, 1'b0, 32'h0);
        cycle();
        check_eq("haz_young_pend_x3", rs1_stall, 1'b1);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h77);
        cycle();
        check_eq("haz_released_x3", rs1_stall, 1'b0);
        idle();
        repeat (3) cycle();

        // Late writes to x0 never go pending and never write.
        drive(1'b1, 1'b1, 5'd0, 32'h55, 1'b1, 1'b0, 32'h0);
        cycle();
        check_eq("x0_late_busy", late_busy, 1'b0);
        check_eq("x0_fwd0_wen", fwd_0_wen, 1'b0);
        check_eq("x0_ready", ex_ready, 1'b1);
        idle();
        repeat (3) cycle();

        // Reset while stalled drops the pending entry; later late data is ignored.
        drive(1'b1, 1'b1, 5'd7, 32'h0, 1'b1, 1'b0, 32'h0);
        cycle();
        idle();
        repeat (3) cycle();
        do_reset();
        check_eq("rstmid_rd_wen", rd_wen, 1'b0);
        check_eq("rstmid_late_busy", late_busy, 1'b0);
        check_eq("rstmid_ready", ex_ready, 1'b1);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'hABCD);
        cycle();
        idle();
        for (int k = 0; k < 3; k++) begin
            check_eq("rstmid_no_commit", rd_wen, 1'b0);
            cycle();
        end
`else
        // Without late support, late controls change nothing.
        rs1_addr = 5'd5;
        rs2_addr = 5'd6;
        pipeline_pair(1'b1, 1'b1);
        check_eq("nolate_busy", late_busy, 1'b0);
        check_eq("nolate_rs1_stall", rs1_stall, 1'b0);
`endif

        // Random traffic on a small address range so hazards collide often.
        for (int k = 0; k < 600; k++) begin
            rst        = ($urandom_range(0, 59) == 0);
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_wen     = ($urandom_range(0, 4) != 0);
            ex_addr    = 5'($urandom_range(0, 7));
            ex_wdata   = $urandom;
            ex_late    = ($urandom_range(0, 3) == 0);
            late_valid = ($urandom_range(0, 3) == 0);
            late_wdata = $urandom;
            rs1_addr   = 5'($urandom_range(0, 7));
            rs2_addr   = 5'($urandom_range(0, 7));
            cycle();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
